// File: rtl/latch_write_seq.sv
// Write sequencer for a bank of level-sensitive D-latch storage words.
// A request accepted on the valid/ready port is driven onto the shared D bus,
// the selected latch enable is pulsed after a setup window, the data is held
// for a hold window, and the word's Q is then compared against what was written.
module latch_write_seq #(
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    output logic [DW-1:0]        lat_d,
    output logic [(1<<AW)-1:0]   lat_c,
    input  logic [DW-1:0]        lat_q,
    output logic [AW-1:0]        lat_sel,
    output logic                 done,
    output logic                 err
);

    localparam int NW    = 1 << AW;
    localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC  = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   lat_d_nxt;
    logic [NW-1:0]   lat_c_nxt;
    logic [AW-1:0]   lat_sel_nxt;
    logic            wr_ready_nxt;
    logic            done_nxt;
    logic            err_nxt;

    // Register the phase state and every output so the latch array only ever sees
    // glitch-free flop outputs; reset kills any enable pulse immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_d    <= '0;
            lat_c    <= '0;
            lat_sel  <= '0;
            wr_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lat_d    <= lat_d_nxt;
            lat_c    <= lat_c_nxt;
            lat_sel  <= lat_sel_nxt;
            wr_ready <= wr_ready_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // Phase sequencing: each phase loads its down-counter on entry and leaves when
    // the counter reaches zero; the enable value is computed one cycle ahead so the
    // registered lat_c is high for exactly the pulse phase.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lat_d_nxt    = lat_d;
        lat_c_nxt    = '0;
        lat_sel_nxt  = lat_sel;
        wr_ready_nxt = wr_ready;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    lat_d_nxt    = wr_data;
                    lat_sel_nxt  = wr_addr;
                    wr_ready_nxt = 1'b0;
                    cnt_nxt      = CW'(SETUP_CYC - 1);
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_nxt   = CW'(PULSE_CYC - 1);
                    lat_c_nxt = NW'(1) << lat_sel;
                    state_nxt = PULSE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    cnt_nxt   = CW'(HOLD_CYC - 1);
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                    lat_c_nxt = NW'(1) << lat_sel;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    done_nxt     = 1'b1;
                    err_nxt      = (lat_q != lat_d);
                    wr_ready_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_latch_write_seq.sv
// Bench for latch_write_seq: a timeline model (cycles elapsed since acceptance)
// checks the default-parameter instance every cycle, directed writes pin the model
// with literal cycle expectations, and a second instance covers S=3,P=1,H=2.
module tb_latch_write_seq;

    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
    localparam int T = S + P + H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] lat_d;
    logic [3:0] lat_c;
    logic [7:0] lat_q;
    logic [1:0] lat_sel;
    logic       done;
    logic       err;

    logic       alt_valid;
    logic       alt_ready;
    logic [1:0] alt_addr;
    logic [7:0] alt_data;
    logic [7:0] alt_lat_d;
    logic [3:0] alt_lat_c;
    logic [7:0] alt_q;
    logic [1:0] alt_sel;
    logic       alt_done;
    logic       alt_err;

    logic [7:0] mem [4];
    bit         q_zero;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_seen = 0;

    bit         m_act = 1'b0;
    int         m_acc = 0;
    logic [7:0] m_d = 8'h00;
    logic [1:0] m_sel = 2'd0;
    logic [7:0] q_snap = 8'h00;

    latch_write_seq u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lat_d    (lat_d),
        .lat_c    (lat_c),
        .lat_q    (lat_q),
        .lat_sel  (lat_sel),
        .done     (done),
        .err      (err)
    );

    latch_write_seq #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_alt (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (alt_valid),
        .wr_ready (alt_ready),
        .wr_addr  (alt_addr),
        .wr_data  (alt_data),
        .lat_d    (alt_lat_d),
        .lat_c    (alt_lat_c),
        .lat_q    (alt_q),
        .lat_sel  (alt_sel),
        .done     (alt_done),
        .err      (alt_err)
    );

    // Free-running clock and an edge counter used as the bench's time base.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural latch array: each word is transparent while its enable is high.
    always_latch begin
        for (int i = 0; i < 4; i++) begin
            if (lat_c[i]) mem[i] <= lat_d;
        end
    end

    assign lat_q = q_zero ? 8'h00 : mem[lat_sel];
    assign alt_q = 8'h5A;

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: outputs follow from the number of edges elapsed since the
    // accepting edge, checked at every falling edge.
    initial begin
        int         e;
        bit         busy;
        bit         ex_done;
        bit         ex_err;
        logic [3:0] ex_c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_act = 1'b0;
                m_d   = 8'h00;
                m_sel = 2'd0;
                busy  = 1'b0;
                ex_done = 1'b0;
                ex_err  = 1'b0;
                ex_c    = 4'b0000;
            end else begin
                e       = cyc - m_acc;
                busy    = m_act && (e < T);
                ex_done = m_act && (e == T);
                ex_c    = (m_act && e >= S && e < S + P) ? (4'b0001 << m_sel) : 4'b0000;
                ex_err  = ex_done && (q_snap !== m_d);
                if (m_act && e == T - 1) q_snap = lat_q;
            end
            if (done === 1'b1) done_seen++;
            check_output("model_ready", 32'(wr_ready), 32'(!busy));
            check_output("model_lat_c", 32'(lat_c), 32'(ex_c));
            check_output("model_done",  32'(done), 32'(ex_done));
            check_output("model_err",   32'(err), 32'(ex_err));
            check_output("model_lat_d", 32'(lat_d), 32'(m_d));
            check_output("model_sel",   32'(lat_sel), 32'(m_sel));
            if (rst_n) begin
                if (ex_done) m_act = 1'b0;
                if (!busy && wr_valid) begin
                    m_act = 1'b1;
                    m_acc = cyc + 1;
                    m_d   = wr_data;
                    m_sel = wr_addr;
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!wr_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!wr_ready) check_output("wait_ready_timeout", 32'(wr_ready), 32'd1);
    endtask

    // One directed write with literal cycle expectations for the default timing;
    // optionally pokes a competing request while the enable is high.
    task automatic apply_stimulus(input logic [1:0] a, input logic [7:0] d,
                                  input bit exp_err, input bit poke);
        wait_ready();
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (poke) begin
                if (e == 1) begin
                    wr_valid = 1'b1;
                    wr_data  = ~d;
                    wr_addr  = a + 2'd1;
                end else begin
                    wr_valid = 1'b0;
                end
            end
            @(negedge clk);
            check_output("lit_lat_c", 32'(lat_c), (e == 1 || e == 2) ? 32'(4'b0001 << a) : 32'd0);
            check_output("lit_done",  32'(done), 32'(e == 4));
            check_output("lit_err",   32'(err), 32'(e == 4 && exp_err));
            check_output("lit_lat_d", 32'(lat_d), 32'(d));
        end
        @(posedge clk); #1;
    endtask

    // Directed write on the S=3,P=1,H=2 instance: enable high only one cycle after
    // three setup cycles, done three cycles after that.
    task automatic apply_alt(input logic [1:0] a);
        int k = 0;
        while (!alt_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        alt_addr  = a;
        alt_data  = 8'h5A;
        alt_valid = 1'b1;
        @(posedge clk); #1;
        alt_valid = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            check_output("alt_lat_c",  32'(alt_lat_c), (e == 3) ? 32'(4'b0001 << a) : 32'd0);
            check_output("alt_done",   32'(alt_done), 32'(e == 6));
            check_output("alt_err",    32'(alt_err), 32'd0);
            check_output("alt_ready",  32'(alt_ready), 32'(e >= 6));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_cyc [4];
        int base;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = 2'd0;
        wr_data   = 8'h00;
        alt_valid = 1'b0;
        alt_addr  = 2'd0;
        alt_data  = 8'h00;
        q_zero    = 1'b0;
        $display("[TB] reset");
        @(negedge clk);
        check_output("rst_ready", 32'(wr_ready), 32'd1);
        check_output("rst_lat_c", 32'(lat_c), 32'd0);
        check_output("rst_done",  32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single write addr=2 data=A5");
        apply_stimulus(2'd2, 8'hA5, 1'b0, 1'b0);

        $display("[TB] readback mismatch");
        q_zero = 1'b1;
        apply_stimulus(2'd1, 8'h3C, 1'b1, 1'b0);
        q_zero = 1'b0;

        $display("[TB] busy poke during pulse");
        apply_stimulus(2'd3, 8'h96, 1'b0, 1'b1);

        $display("[TB] back-to-back writes");
        wait_ready();
        base     = done_seen;
        wr_addr  = 2'd0;
        wr_data  = 8'h11;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            @(posedge clk); #1;
            acc_cyc[i] = cyc;
            wr_addr = 2'(i + 1);
            wr_data = 8'(8'h11 * (i + 2));
        end
        wr_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check_output("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
        end
        repeat (6) @(posedge clk);
        #1;
        check_output("b2b_done_count", 32'(done_seen - base), 32'd4);

        $display("[TB] reset during pulse");
        wait_ready();
        wr_addr  = 2'd1;
        wr_data  = 8'hC3;
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(posedge clk); #1;
        check_output("pre_rst_lat_c", 32'(lat_c), 32'b0010);
        #1 rst_n = 1'b0;
        #1;
        check_output("async_rst_lat_c", 32'(lat_c), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_ready", 32'(wr_ready), 32'd1);
        check_output("post_rst_done",  32'(done), 32'd0);

        $display("[TB] alternate timing instance");
        @(posedge clk); #1;
        apply_alt(2'd2);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_data  = 8'($urandom_range(0, 255));
            q_zero   = ($urandom_range(0, 7) == 0);
        end
        wr_valid = 1'b0;
        q_zero   = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
